// File: rtl/insel_sync_ctrl.sv
// Input-select sequencer: applies a new select map on frame sync (or at once), then blanks for a settle window.
// Latency: one cycle from sync_in/ctrl edge to insel_out and sync_out; no backpressure, every input is sampled each cycle.
module insel_sync_ctrl #(
   parameter int N_INPUTS   = 4,
   parameter int SEL_W      = 2,
   parameter int SETTLE_CYC = 16,
   parameter int CNT_W      = 16
) (
   input  logic                        user_clk,
   input  logic                        user_rst_n,
   input  logic [31:0]                 ctrl_word,
   input  logic                        sync_in,
   output logic [N_INPUTS*SEL_W-1:0]   insel_out,
   output logic                        sync_out,
   output logic                        blank,
   output logic                        armed,
   output logic                        busy,
   output logic [CNT_W-1:0]            apply_count
);

   localparam int MW = N_INPUTS * SEL_W;
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

   typedef enum logic [1:0] {IDLE, ARMED, SETTLE} state_t;

   state_t          state;
   logic [MW-1:0]   pending;
   logic            pend_vld;
   logic [CW-1:0]   cnt;
   logic            arm_prev, now_prev;
   logic            arm_edge, now_edge;
   logic            do_apply;
   logic [MW-1:0]   map, apply_map;
   logic            unused_ctrl;

   assign map         = ctrl_word[MW-1:0];
   assign arm_edge    = ctrl_word[16] & ~arm_prev;
   assign now_edge    = ctrl_word[17] & ~now_prev;
   assign unused_ctrl = ^ctrl_word;

   // now_edge always outranks sync; sync only applies from ARMED
   always_comb begin
      do_apply  = 1'b0;
      apply_map = map;
      case (state)
         IDLE:    do_apply = now_edge;
         ARMED: begin
            do_apply  = now_edge | sync_in;
            apply_map = now_edge ? map : pending;
         end
         SETTLE:  do_apply = now_edge;
         default: do_apply = 1'b0;
      endcase
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state       <= IDLE;
         pending     <= '0;
         pend_vld    <= 1'b0;
         cnt         <= '0;
         arm_prev    <= 1'b1;
         now_prev    <= 1'b1;
         insel_out   <= '0;
         sync_out    <= 1'b0;
         blank       <= 1'b0;
         armed       <= 1'b0;
         busy        <= 1'b0;
         apply_count <= '0;
      end else begin
         arm_prev <= ctrl_word[16];
         now_prev <= ctrl_word[17];
         sync_out <= sync_in;
         if (do_apply) begin
            insel_out   <= apply_map;
            apply_count <= apply_count + 1'b1;
            pend_vld    <= 1'b0;
            armed       <= 1'b0;
            if (SETTLE_CYC > 0) begin
               state <= SETTLE;
               cnt   <= CNT_LOAD;
               blank <= 1'b1;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               blank <= 1'b0;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (arm_edge) begin
                     pending <= map;
                     state   <= ARMED;
                     armed   <= 1'b1;
                     busy    <= 1'b1;
                  end
               end
               ARMED: begin
                  if (arm_edge) pending <= map;
               end
               SETTLE: begin
                  if (arm_edge) begin
                     pending  <= map;
                     pend_vld <= 1'b1;
                  end
                  // an arm seen during settle is held until the window closes
                  if (cnt == '0) begin
                     blank    <= 1'b0;
                     pend_vld <= 1'b0;
                     if (arm_edge || pend_vld) begin
                        state <= ARMED;
                        armed <= 1'b1;
                        busy  <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  armed <= 1'b0;
                  busy  <= 1'b0;
                  blank <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_insel_sync_ctrl.sv
// Bench for insel_sync_ctrl: settle-16 and settle-0 builds side by side against a behavioural model.
module tb_insel_sync_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ctrl  = 32'h0;
   logic        sync  = 1'b0;

   logic [7:0]  insel  [2];
   logic        sync_o [2];
   logic        blank  [2];
   logic        armed  [2];
   logic        busy   [2];
   logic [15:0] acnt   [2];

   always #5 clk = ~clk;

   insel_sync_ctrl #(.N_INPUTS(4), .SEL_W(2), .SETTLE_CYC(16), .CNT_W(16)) dut16 (
      .user_clk(clk), .user_rst_n(rst_n), .ctrl_word(ctrl), .sync_in(sync),
      .insel_out(insel[0]), .sync_out(sync_o[0]), .blank(blank[0]),
      .armed(armed[0]), .busy(busy[0]), .apply_count(acnt[0]));

   insel_sync_ctrl #(.N_INPUTS(4), .SEL_W(2), .SETTLE_CYC(0), .CNT_W(16)) dut0 (
      .user_clk(clk), .user_rst_n(rst_n), .ctrl_word(ctrl), .sync_in(sync),
      .insel_out(insel[1]), .sync_out(sync_o[1]), .blank(blank[1]),
      .armed(armed[1]), .busy(busy[1]), .apply_count(acnt[1]));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: the active map, an optional pending map, remaining blank cycles, apply tally.
   logic [7:0] m_act  [2];
   bit         m_pv   [2];
   logic [7:0] m_pm   [2];
   int         m_bl   [2];
   int         m_napp [2];
   bit         m_sync, m_ap, m_np;

   function automatic int settle_of(input int k);
      return (k == 0) ? 16 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_act[k] = 8'h0; m_pv[k] = 1'b0; m_pm[k] = 8'h0; m_bl[k] = 0; m_napp[k] = 0;
      end
      m_sync = 1'b0; m_ap = 1'b1; m_np = 1'b1;
   endtask

   task automatic model_step();
      bit arm_e, now_e;
      arm_e = ctrl[16] && !m_ap;
      now_e = ctrl[17] && !m_np;
      for (int k = 0; k < 2; k++) begin
         if (now_e) begin
            m_act[k] = ctrl[7:0]; m_napp[k]++; m_pv[k] = 1'b0; m_bl[k] = settle_of(k);
         end else if (m_bl[k] > 0) begin
            m_bl[k]--;
            if (arm_e) begin m_pv[k] = 1'b1; m_pm[k] = ctrl[7:0]; end
         end else if (m_pv[k]) begin
            if (sync) begin
               m_act[k] = m_pm[k]; m_napp[k]++; m_pv[k] = 1'b0; m_bl[k] = settle_of(k);
            end else if (arm_e) m_pm[k] = ctrl[7:0];
         end else if (arm_e) begin
            m_pv[k] = 1'b1; m_pm[k] = ctrl[7:0];
         end
      end
      m_sync = sync; m_ap = ctrl[16]; m_np = ctrl[17];
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("insel[%0d]", k), 32'(insel[k]), 32'(m_act[k]));
         check($sformatf("sync_out[%0d]", k), 32'(sync_o[k]), 32'(m_sync));
         check($sformatf("blank[%0d]", k), 32'(blank[k]), 32'(m_bl[k] > 0));
         check($sformatf("armed[%0d]", k), 32'(armed[k]), 32'(m_pv[k] && m_bl[k] == 0));
         check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_pv[k] || m_bl[k] > 0));
         check($sformatf("apply_count[%0d]", k), 32'(acnt[k]), 32'(m_napp[k] & 16'hFFFF));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   // Asserted mid-cycle, held across one edge, released just after the next edge.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   task automatic pulse_sync();
      sync = 1'b1; cycle(); sync = 1'b0;
   endtask

   initial begin
      logic [31:0] rnd;
      model_reset();
      ctrl = 32'h0001_00E4;
      #1;
      check_all();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(20);

      // arm 0xE4, apply on sync ten cycles later
      ctrl = 32'h0; cycle();
      ctrl = 32'h0001_00E4; idle(10);
      check("armed_before_sync", 32'(armed[0]), 32'h1);
      pulse_sync();
      check("e4_insel", 32'(insel[0]), 32'hE4);
      check("e4_sync_out", 32'(sync_o[0]), 32'h1);
      check("e4_count", 32'(acnt[0]), 32'h1);
      idle(15);
      check("blank_last", 32'(blank[0]), 32'h1);
      cycle();
      check("blank_done", 32'(blank[0]), 32'h0);
      check("busy_done", 32'(busy[0]), 32'h0);
      idle(3);

      // re-arm before sync: last map wins
      ctrl = 32'h0; cycle();
      ctrl = 32'h0001_001B; idle(3);
      ctrl = 32'h0000_001B; cycle();
      ctrl = 32'h0001_004E; idle(3);
      pulse_sync();
      check("rearm_insel", 32'(insel[0]), 32'h4E);
      check("rearm_count", 32'(acnt[0]), 32'h2);
      idle(20);

      // apply_now with sync in ARMED: one apply, pending dropped
      ctrl = 32'h0; cycle();
      ctrl = 32'h0001_001B; idle(3);
      ctrl = 32'h0003_0055; pulse_sync();
      check("now_insel", 32'(insel[0]), 32'h55);
      check("now_count", 32'(acnt[0]), 32'h3);
      idle(20);
      pulse_sync(); idle(3);

      // arm 0xFF then sync; settle-0 build returns to idle at once
      ctrl = 32'h0; cycle();
      ctrl = 32'h0001_00FF; idle(4);
      pulse_sync();
      check("ff_insel_s0", 32'(insel[1]), 32'hFF);
      check("ff_blank_s0", 32'(blank[1]), 32'h0);
      check("ff_busy_s0", 32'(busy[1]), 32'h0);
      idle(4);

      // reset mid-settle, later sync must not apply
      ctrl = 32'h0; cycle();
      ctrl = 32'h0001_0033; idle(2);
      pulse_sync(); idle(5);
      async_reset();
      idle(3); pulse_sync(); idle(3);
      check("rst_settle_count", 32'(acnt[0]), 32'h0);

      // reset while armed
      ctrl = 32'h0; cycle();
      ctrl = 32'h0001_0099; idle(3);
      async_reset();
      idle(3); pulse_sync(); idle(3);
      check("rst_armed_insel", 32'(insel[0]), 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rnd = $urandom();
         if ($urandom_range(0, 9) == 0) begin
            ctrl[31:18] = rnd[31:18];
            ctrl[15:0]  = rnd[15:0];
         end
         if ($urandom_range(0, 99) < 8) ctrl[16] = ~ctrl[16];
         if ($urandom_range(0, 99) < 4) ctrl[17] = ~ctrl[17];
         sync = ($urandom_range(0, 29) == 0);
         cycle();
         if ($urandom_range(0, 999) == 0) async_reset();
      end
      sync = 1'b0;
      idle(20);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
